// File: rtl/wallet_arbiter.sv
// Game wallet: balance with level-scaled income and cap, round-robin purchase
// arbitration over NUM_REQ channels, and a level-upgrade path that takes priority.

module wallet_chan #(
   parameter int BAL_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [BAL_W-1:0] cost,
   input  logic             grant,
   output logic             pend,
   output logic [BAL_W-1:0] cost_q
);
   // A grant only happens while pend is set, so a req in the grant cycle is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend   <= 1'b0;
         cost_q <= '0;
      end else if (grant) begin
         pend   <= 1'b0;
      end else if (req && !pend) begin
         pend   <= 1'b1;
         cost_q <= cost;
      end
   end
endmodule

module wallet_arbiter #(
   parameter int BAL_W         = 16,
   parameter int NUM_REQ       = 4,
   parameter int LEVELS        = 4,
   parameter int BASE_CAP      = 256,
   parameter int BASE_INCOME   = 1,
   parameter int UPG_BASE_COST = 100,
   localparam int IW = $clog2(NUM_REQ),
   localparam int LW = $clog2(LEVELS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*BAL_W-1:0] cost,
   input  logic                     upgrade_req,
   output logic [BAL_W-1:0]         balance,
   output logic [LW-1:0]            level,
   output logic [BAL_W-1:0]         cap,
   output logic                     maxed,
   output logic                     done,
   output logic [IW-1:0]            done_idx,
   output logic                     done_ok,
   output logic                     upg_done,
   output logic                     upg_ok,
   output logic [NUM_REQ-1:0]       pending
);
   logic [NUM_REQ-1:0][BAL_W-1:0] cost_q;
   logic [NUM_REQ-1:0]            grant;
   logic [IW-1:0]                 rr_ptr, rr_nxt, gnt_idx;
   logic                          gnt_found, upg_pend;
   logic                          upg_go, upg_afford, pur_go, pur_ok;
   logic [BAL_W-1:0]              upg_cost, bal_dec, bal_nxt, cap_nxt;
   logic [LW-1:0]                 lvl_nxt;
   logic [BAL_W:0]                income, sum;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_chan
      wallet_chan #(.BAL_W(BAL_W)) u_chan (
         .clk    (clk),
         .rst    (rst),
         .req    (req[g]),
         .cost   (cost[g*BAL_W +: BAL_W]),
         .grant  (grant[g]),
         .pend   (pending[g]),
         .cost_q (cost_q[g])
      );
   end

   // First pending channel at or after rr_ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!gnt_found && pending[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = IW'(idx);
         end
      end
   end

   always_comb begin
      upg_go     = upg_pend;
      pur_go     = !upg_pend && gnt_found;
      upg_cost   = BAL_W'(UPG_BASE_COST) << level;
      upg_afford = (level != LW'(LEVELS-1)) && (balance >= upg_cost);
      pur_ok     = balance >= cost_q[gnt_idx];
      grant      = '0;
      rr_nxt     = rr_ptr;
      bal_dec    = balance;
      lvl_nxt    = level;
      cap_nxt    = cap;
      if (pur_go) begin
         grant[gnt_idx] = 1'b1;
         rr_nxt = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (upg_go && upg_afford) begin
         bal_dec = balance - upg_cost;
         lvl_nxt = level + 1'b1;
         cap_nxt = cap << 1;
      end else if (pur_go && pur_ok) begin
         bal_dec = balance - cost_q[gnt_idx];
      end
      // Income uses the pre-decision level; the clamp uses the post-decision cap.
      income  = (BAL_W+1)'(BASE_INCOME) << level;
      sum     = {1'b0, bal_dec} + income;
      bal_nxt = bal_dec;
      if (tick)
         bal_nxt = (sum > {1'b0, cap_nxt}) ? cap_nxt : sum[BAL_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         balance  <= '0;
         level    <= '0;
         cap      <= BAL_W'(BASE_CAP);
         maxed    <= 1'b0;
         rr_ptr   <= '0;
         upg_pend <= 1'b0;
         done     <= 1'b0;
         done_idx <= '0;
         done_ok  <= 1'b0;
         upg_done <= 1'b0;
         upg_ok   <= 1'b0;
      end else begin
         balance  <= bal_nxt;
         level    <= lvl_nxt;
         cap      <= cap_nxt;
         maxed    <= (lvl_nxt == LW'(LEVELS-1));
         rr_ptr   <= rr_nxt;
         if (upg_go)
            upg_pend <= 1'b0;
         else if (upgrade_req)
            upg_pend <= 1'b1;
         done     <= pur_go;
         done_idx <= pur_go ? gnt_idx : '0;
         done_ok  <= pur_go && pur_ok;
         upg_done <= upg_go;
         upg_ok   <= upg_go && upg_afford;
      end
   end
endmodule

// File: tb/tb_wallet_arbiter.sv
// Directed bench for wallet_arbiter: income/cap, purchases, round-robin, upgrades, reset.

module tb_wallet_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic [3:0]  req = '0;
   logic [63:0] cost = '0;
   logic        upgrade_req = 1'b0;
   logic [15:0] balance, cap;
   logic [1:0]  level, done_idx;
   logic        maxed, done, done_ok, upg_done, upg_ok;
   logic [3:0]  pending;
   int total = 0;
   int bad = 0;

   wallet_arbiter dut (
      .clk(clk), .rst(rst), .tick(tick), .req(req), .cost(cost),
      .upgrade_req(upgrade_req), .balance(balance), .level(level), .cap(cap),
      .maxed(maxed), .done(done), .done_idx(done_idx), .done_ok(done_ok),
      .upg_done(upg_done), .upg_ok(upg_ok), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1; req = '0; tick = 1'b0; upgrade_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic set_cost(input int i, input logic [15:0] v);
      cost[i*16 +: 16] = v;
   endtask

   task automatic upgrade_pulse();
      upgrade_req = 1'b1;
      @(negedge clk);
      upgrade_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      total++; if (balance !== 16'd0) begin bad++; $display("FAIL rst_balance got=%0d exp=0", balance); end
      total++; if (level !== 2'd0 || maxed !== 1'b0) begin bad++; $display("FAIL rst_level got=%0d/%0b exp=0/0", level, maxed); end
      total++; if (cap !== 16'd256) begin bad++; $display("FAIL rst_cap got=%0d exp=256", cap); end
      total++; if (pending !== 4'b0 || done !== 1'b0 || upg_done !== 1'b0 || done_ok !== 1'b0 || upg_ok !== 1'b0)
         begin bad++; $display("FAIL rst_pulses got=%b/%b/%b exp=0/0/0", pending, done, upg_done); end
      rst = 1'b0;
   endtask

   task automatic test_income();
      do_reset();
      tick = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         total++;
         if (balance !== ((i < 256) ? i : 256)) begin
            bad++; $display("FAIL income_t%0d got=%0d exp=%0d", i, balance, (i < 256) ? i : 256);
         end
      end
      tick = 1'b0;
      total++; if (cap !== 16'd256) begin bad++; $display("FAIL income_cap got=%0d exp=256", cap); end
   endtask

   task automatic test_purchase();
      do_reset();
      ticks(50);
      total++; if (balance !== 16'd50) begin bad++; $display("FAIL pur_start got=%0d exp=50", balance); end
      req = 4'b0100; set_cost(2, 16'd30);
      @(negedge clk); req = '0;
      total++; if (pending !== 4'b0100 || done !== 1'b0) begin bad++; $display("FAIL pur_pend got=%b/%b exp=0100/0", pending, done); end
      @(negedge clk);
      total++; if (done !== 1'b1 || done_idx !== 2'd2 || done_ok !== 1'b1 || balance !== 16'd20)
         begin bad++; $display("FAIL pur_ok got=%b/%0d/%b/%0d exp=1/2/1/20", done, done_idx, done_ok, balance); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL pur_pulse got=%b exp=0", done); end
      req = 4'b0100;
      @(negedge clk); req = '0;
      @(negedge clk);
      total++; if (done !== 1'b1 || done_ok !== 1'b0 || balance !== 16'd20)
         begin bad++; $display("FAIL pur_poor got=%b/%b/%0d exp=1/0/20", done, done_ok, balance); end
      // Repeat while pending is dropped and must not overwrite the latched cost.
      req = 4'b0010; set_cost(1, 16'd5);
      @(negedge clk); set_cost(1, 16'd99);
      total++; if (pending !== 4'b0010) begin bad++; $display("FAIL pur_dup_pend got=%b exp=0010", pending); end
      @(negedge clk); req = '0;
      total++; if (done !== 1'b1 || done_idx !== 2'd1 || done_ok !== 1'b1 || balance !== 16'd15)
         begin bad++; $display("FAIL pur_dup got=%b/%0d/%b/%0d exp=1/1/1/15", done, done_idx, done_ok, balance); end
      @(negedge clk);
      total++; if (done !== 1'b0 || pending !== 4'b0) begin bad++; $display("FAIL pur_dup_drop got=%b/%b exp=0/0000", done, pending); end
      req = 4'b0001; set_cost(0, 16'd0);
      @(negedge clk); req = '0;
      @(negedge clk);
      total++; if (done !== 1'b1 || done_ok !== 1'b1 || balance !== 16'd15)
         begin bad++; $display("FAIL pur_zero got=%b/%b/%0d exp=1/1/15", done, done_ok, balance); end
   endtask

   task automatic test_round_robin();
      do_reset();
      ticks(256);
      req = 4'b1111;
      for (int i = 0; i < 4; i++) set_cost(i, 16'd10);
      @(negedge clk); req = '0;
      total++; if (pending !== 4'b1111) begin bad++; $display("FAIL rr_pend got=%b exp=1111", pending); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (done !== 1'b1 || done_idx !== 2'(k) || done_ok !== 1'b1)
            begin bad++; $display("FAIL rr_seq%0d got=%b/%0d/%b exp=1/%0d/1", k, done, done_idx, done_ok, k); end
      end
      total++; if (balance !== 16'd216) begin bad++; $display("FAIL rr_bal got=%0d exp=216", balance); end
      req = 4'b1001;
      @(negedge clk); req = '0;
      @(negedge clk);
      total++; if (done !== 1'b1 || done_idx !== 2'd0) begin bad++; $display("FAIL rr_wrap0 got=%b/%0d exp=1/0", done, done_idx); end
      @(negedge clk);
      total++; if (done !== 1'b1 || done_idx !== 2'd3 || balance !== 16'd196)
         begin bad++; $display("FAIL rr_wrap3 got=%b/%0d/%0d exp=1/3/196", done, done_idx, balance); end
   endtask

   task automatic test_upgrade();
      ticks(60);
      total++; if (balance !== 16'd256) begin bad++; $display("FAIL upg_start got=%0d exp=256", balance); end
      upgrade_pulse();
      total++; if (upg_done !== 1'b1 || upg_ok !== 1'b1 || level !== 2'd1 || balance !== 16'd156 || cap !== 16'd512)
         begin bad++; $display("FAIL upg_ok got=%b/%b/%0d/%0d/%0d exp=1/1/1/156/512", upg_done, upg_ok, level, balance, cap); end
      ticks(1);
      total++; if (balance !== 16'd158) begin bad++; $display("FAIL upg_income got=%0d exp=158", balance); end
      upgrade_req = 1'b1; req = 4'b0010; set_cost(1, 16'd5);
      @(negedge clk); upgrade_req = 1'b0; req = '0;
      @(negedge clk);
      total++; if (upg_done !== 1'b1 || upg_ok !== 1'b0 || done !== 1'b0)
         begin bad++; $display("FAIL upg_first got=%b/%b/%b exp=1/0/0", upg_done, upg_ok, done); end
      @(negedge clk);
      total++; if (done !== 1'b1 || done_idx !== 2'd1 || upg_done !== 1'b0 || balance !== 16'd153)
         begin bad++; $display("FAIL upg_then_pur got=%b/%0d/%b/%0d exp=1/1/0/153", done, done_idx, upg_done, balance); end
   endtask

   task automatic test_maxed();
      ticks(24);
      upgrade_pulse();
      total++; if (level !== 2'd2 || balance !== 16'd1 || cap !== 16'd1024 || maxed !== 1'b0)
         begin bad++; $display("FAIL max_l2 got=%0d/%0d/%0d/%b exp=2/1/1024/0", level, balance, cap, maxed); end
      ticks(100);
      upgrade_pulse();
      total++; if (level !== 2'd3 || balance !== 16'd1 || cap !== 16'd2048 || maxed !== 1'b1 || upg_ok !== 1'b1)
         begin bad++; $display("FAIL max_l3 got=%0d/%0d/%0d/%b exp=3/1/2048/1", level, balance, cap, maxed); end
      upgrade_pulse();
      total++; if (upg_done !== 1'b1 || upg_ok !== 1'b0 || level !== 2'd3 || balance !== 16'd1)
         begin bad++; $display("FAIL max_again got=%b/%b/%0d/%0d exp=1/0/3/1", upg_done, upg_ok, level, balance); end
      ticks(1);
      total++; if (balance !== 16'd9) begin bad++; $display("FAIL max_income got=%0d exp=9", balance); end
   endtask

   task automatic test_tick_purchase_reset();
      do_reset();
      ticks(10);
      req = 4'b0001; set_cost(0, 16'd10);
      @(negedge clk); req = '0; tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      total++; if (done !== 1'b1 || done_ok !== 1'b1 || balance !== 16'd1)
         begin bad++; $display("FAIL tick_pur got=%b/%b/%0d exp=1/1/1", done, done_ok, balance); end
      req = 4'b0101; set_cost(0, 16'd1); set_cost(2, 16'd1);
      @(negedge clk); req = '0;
      total++; if (pending !== 4'b0101) begin bad++; $display("FAIL rst_mid_pend got=%b exp=0101", pending); end
      rst = 1'b1;
      #1;
      total++; if (pending !== 4'b0) begin bad++; $display("FAIL rst_mid_clear got=%b exp=0000", pending); end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (done !== 1'b0 || upg_done !== 1'b0) begin bad++; $display("FAIL rst_mid_quiet%0d got=%b/%b exp=0/0", i, done, upg_done); end
      end
      total++; if (balance !== 16'd0) begin bad++; $display("FAIL rst_mid_bal got=%0d exp=0", balance); end
   endtask

   initial begin
      test_reset();
      test_income();
      test_purchase();
      test_round_robin();
      test_upgrade();
      test_maxed();
      test_tick_purchase_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
